// File: rtl/emc_capture_slave_if.sv
// EMC chip-select bus between the MSS (master) and the fabric capture responder (slave).
// Signal names follow the EMC pad names used elsewhere in the capture design.
interface emc_capture_slave_if #(
    parameter int unsigned AW = 26
);
    logic          EMC_CS_N;
    logic          EMC_RW_N;
    logic          EMC_OEN_N;
    logic [AW-1:0] EMC_AB;
    logic [1:0]    EMC_BYTEN;
    logic [15:0]   EMC_DB_IN;
    logic [15:0]   EMC_DB_OUT;
    logic          EMC_DB_OE;

    modport master (
        output EMC_CS_N, EMC_RW_N, EMC_OEN_N, EMC_AB, EMC_BYTEN, EMC_DB_IN,
        input  EMC_DB_OUT, EMC_DB_OE
    );

    modport slave (
        input  EMC_CS_N, EMC_RW_N, EMC_OEN_N, EMC_AB, EMC_BYTEN, EMC_DB_IN,
        output EMC_DB_OUT, EMC_DB_OE
    );
endinterface

// File: rtl/emc_capture_slave.sv
// EMC slave that buffers capture pixels in a FIFO and exposes CTRL/STATUS/DATA/LEVEL registers.
// Optional 16-bit saturating DROPS counter at word index 4 when EMC_CAPTURE_DROP_COUNT_EN is defined.
module emc_capture_slave #(
    parameter int unsigned AW              = 26,
    parameter int unsigned FIFO_DEPTH_LOG2 = 6,
    parameter int unsigned IRQ_THRESH      = 32
) (
    input  logic                SYSCLK,
    input  logic                SYSRESET,
    emc_capture_slave_if.slave  emc,
    input  logic                PIX_VALID,
    input  logic [15:0]         PIX_DATA,
    output logic                CAP_EN,
    output logic                IRQ
);

    localparam int unsigned DW    = 16;
    localparam int unsigned PW    = FIFO_DEPTH_LOG2;
    localparam int unsigned LW    = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;

    localparam logic [2:0] IDX_CTRL   = 3'd0;
    localparam logic [2:0] IDX_STATUS = 3'd1;
    localparam logic [2:0] IDX_DATA   = 3'd2;
    localparam logic [2:0] IDX_LEVEL  = 3'd3;
    localparam logic [2:0] IDX_DROPS  = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RDRIVE,
        WCOMMIT,
        WAIT_REL
    } state_t;

    state_t         state_q, state_d;
    logic           cs_m, cs_s;

    logic [2:0]     acc_idx;
    logic           acc_rd;
    logic [1:0]     acc_byten;
    logic [DW-1:0]  acc_wdata;
    logic [DW-1:0]  db_out_q;

    logic           enable_q;
    logic           irq_en_q;
    logic           ovf_q;
    logic           irq_q;

    logic [DW-1:0]  mem [DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]  level_q;

    logic           latch_c, load_rd_c, pop_c, commit_c;
    logic           fifo_empty, fifo_full;
    logic           push_req, do_push, drop_c;
    logic           wr_ctrl_lo, fifo_clear_c, ovf_w1c_c;
    logic [DW-1:0]  head_c, rd_data_c, drops_val;

    // Two-flop synchronizer on the asynchronous chip select; idles high.
    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            cs_m <= 1'b1;
            cs_s <= 1'b1;
        end else begin
            cs_m <= emc.EMC_CS_N;
            cs_s <= cs_m;
        end
    end

    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state and per-state strobes; each access pops or commits exactly once.
    always_comb begin
        state_d   = state_q;
        latch_c   = 1'b0;
        load_rd_c = 1'b0;
        pop_c     = 1'b0;
        commit_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cs_s) begin
                    latch_c = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                load_rd_c = acc_rd;
                state_d   = acc_rd ? RDRIVE : WCOMMIT;
            end
            RDRIVE: begin
                if (cs_s) begin
                    pop_c   = (acc_idx == IDX_DATA) && !fifo_empty;
                    state_d = IDLE;
                end
            end
            WCOMMIT: begin
                commit_c = 1'b1;
                state_d  = WAIT_REL;
            end
            WAIT_REL: begin
                if (cs_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            acc_idx   <= 3'd0;
            acc_rd    <= 1'b0;
            acc_byten <= 2'b11;
            acc_wdata <= '0;
        end else if (latch_c) begin
            acc_idx   <= emc.EMC_AB[3:1];
            acc_rd    <= emc.EMC_RW_N;
            acc_byten <= emc.EMC_BYTEN;
            acc_wdata <= emc.EMC_DB_IN;
        end
    end

    // Write decode: only the low lane carries defined CTRL/STATUS bits.
    assign wr_ctrl_lo   = commit_c && (acc_idx == IDX_CTRL) && !acc_byten[0];
    assign fifo_clear_c = wr_ctrl_lo && acc_wdata[1];
    assign ovf_w1c_c    = commit_c && (acc_idx == IDX_STATUS) && !acc_byten[0] && acc_wdata[2];

    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            enable_q <= 1'b0;
            irq_en_q <= 1'b0;
        end else if (wr_ctrl_lo) begin
            enable_q <= acc_wdata[0];
            irq_en_q <= acc_wdata[2];
        end
    end

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LW'(DEPTH));
    assign push_req   = PIX_VALID && enable_q;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_push    = push_req && (!fifo_full || pop_c) && !fifo_clear_c;
    assign drop_c     = push_req && fifo_full && !pop_c && !fifo_clear_c;

    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (fifo_clear_c) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_c)   rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, pop_c})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (do_push) mem[wr_ptr_q] <= PIX_DATA;
    end

    assign head_c = fifo_empty ? '0 : mem[rd_ptr_q];

    // Sticky overflow; a new drop outranks a simultaneous write-1-to-clear.
    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET)       ovf_q <= 1'b0;
        else if (drop_c)    ovf_q <= 1'b1;
        else if (ovf_w1c_c) ovf_q <= 1'b0;
    end

`ifdef EMC_CAPTURE_DROP_COUNT_EN
    logic [DW-1:0] drops_q;

    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET)
            drops_q <= '0;
        else if (commit_c && (acc_idx == IDX_DROPS))
            drops_q <= '0;
        else if (drop_c && (drops_q != 16'hFFFF))
            drops_q <= drops_q + DW'(1);
    end

    assign drops_val = drops_q;
`else
    assign drops_val = '0;
`endif

    always_comb begin
        rd_data_c = '0;
        case (acc_idx)
            IDX_CTRL:   rd_data_c = {13'd0, irq_en_q, 1'b0, enable_q};
            IDX_STATUS: rd_data_c = {8'(level_q), 5'd0, ovf_q, fifo_full, fifo_empty};
            IDX_DATA:   rd_data_c = head_c;
            IDX_LEVEL:  rd_data_c = DW'(level_q);
            IDX_DROPS:  rd_data_c = drops_val;
            default:    rd_data_c = '0;
        endcase
    end

    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET)       db_out_q <= '0;
        else if (load_rd_c) db_out_q <= rd_data_c;
    end

    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) irq_q <= 1'b0;
        else          irq_q <= irq_en_q && ((level_q >= LW'(IRQ_THRESH)) || ovf_q);
    end

    // Pad enable follows raw OEN_N so the MSS sees the bus released as soon as it lets go.
    assign emc.EMC_DB_OE  = (state_q == RDRIVE) && !emc.EMC_OEN_N;
    assign emc.EMC_DB_OUT = db_out_q;
    assign CAP_EN         = enable_q;
    assign IRQ            = irq_q;

    logic unused_bits;
    assign unused_bits = ^{emc.EMC_AB[AW-1:4], emc.EMC_AB[0], acc_byten[1], acc_wdata[DW-1:3]};

endmodule

// File: tb/tb_emc_capture_slave.sv
// Randomized bench for emc_capture_slave against a queue-based register/FIFO model.
// Expected DROPS follows EMC_CAPTURE_DROP_COUNT_EN when the bench is built with it.
module tb_emc_capture_slave;

    localparam int unsigned AW     = 26;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned THRESH = 32;

    logic        SYSCLK = 1'b0;
    logic        SYSRESET;
    logic        PIX_VALID;
    logic [15:0] PIX_DATA;
    logic        CAP_EN;
    logic        IRQ;

    emc_capture_slave_if #(.AW(AW)) bus ();

    emc_capture_slave #(.AW(AW), .FIFO_DEPTH_LOG2(6), .IRQ_THRESH(THRESH)) dut (
        .SYSCLK    (SYSCLK),
        .SYSRESET  (SYSRESET),
        .emc       (bus.slave),
        .PIX_VALID (PIX_VALID),
        .PIX_DATA  (PIX_DATA),
        .CAP_EN    (CAP_EN),
        .IRQ       (IRQ)
    );

    always #5 SYSCLK = ~SYSCLK;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [15:0] mq[$];
    bit          m_en, m_irq_en, m_ovf;
    int          m_drops;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_en = 0; m_irq_en = 0; m_ovf = 0; m_drops = 0;
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] idx);
        logic [15:0] v;
        int sz;
        sz = mq.size();
        case (idx)
            3'd0: v = {13'd0, m_irq_en, 1'b0, m_en};
            3'd1: v = {8'(sz), 5'd0, m_ovf, (sz == DEPTH), (sz == 0)};
            3'd2: v = (sz > 0) ? mq.pop_front() : 16'h0000;
            3'd3: v = 16'(sz);
`ifdef EMC_CAPTURE_DROP_COUNT_EN
            3'd4: v = 16'(m_drops);
`endif
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    task automatic model_write(input logic [2:0] idx, input logic [15:0] wd, input logic [1:0] be);
        if (idx == 3'd0 && !be[0]) begin
            m_en = wd[0];
            m_irq_en = wd[2];
            if (wd[1]) mq.delete();
        end
        if (idx == 3'd1 && !be[0] && wd[2]) m_ovf = 0;
        if (idx == 3'd4) m_drops = 0;
    endtask

    task automatic emc_access(input bit rd, input logic [2:0] idx, input logic [15:0] wd,
                              input logic [1:0] be, input int hold,
                              output logic [15:0] rdata, output bit seen);
        @(negedge SYSCLK);
        bus.EMC_AB    = AW'({idx, 1'b0});
        bus.EMC_RW_N  = rd;
        bus.EMC_BYTEN = be;
        bus.EMC_DB_IN = wd;
        bus.EMC_OEN_N = !rd;
        bus.EMC_CS_N  = 1'b0;
        seen  = 0;
        rdata = 16'h0;
        repeat (hold) begin
            @(negedge SYSCLK);
            if (bus.EMC_DB_OE) begin
                seen  = 1;
                rdata = bus.EMC_DB_OUT;
            end
        end
        bus.EMC_CS_N  = 1'b1;
        bus.EMC_OEN_N = 1'b1;
        repeat (5) @(negedge SYSCLK);
    endtask

    task automatic rd_check(input string tag, input logic [2:0] idx, input int hold);
        logic [15:0] got, exp;
        bit seen;
        exp = model_read(idx);
        emc_access(1'b1, idx, 16'h0, 2'b00, hold, got, seen);
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: DB_OE never asserted within %0d cycles", tag, hold);
        end else begin
            check(tag, 32'(got), 32'(exp));
        end
    endtask

    task automatic wr_reg(input logic [2:0] idx, input logic [15:0] wd, input logic [1:0] be);
        logic [15:0] dummy;
        bit seen;
        emc_access(1'b0, idx, wd, be, 8, dummy, seen);
        model_write(idx, wd, be);
    endtask

    task automatic model_push(input logic [15:0] w);
        if (m_en) begin
            if (mq.size() < DEPTH) mq.push_back(w);
            else begin
                m_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end
        end
    endtask

    task automatic push_words(input int n, input bit rnd, input logic [15:0] base);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            @(negedge SYSCLK);
            w = rnd ? 16'($urandom) : base + 16'(i);
            PIX_VALID = 1'b1;
            PIX_DATA  = w;
            model_push(w);
        end
        @(negedge SYSCLK);
        PIX_VALID = 1'b0;
        repeat (3) @(negedge SYSCLK);
    endtask

    task automatic irq_check(input string tag);
        check(tag, 32'(IRQ), 32'(m_irq_en && (mq.size() >= THRESH || m_ovf)));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] got;
        bit seen;
        int lvl;

        SYSRESET      = 1'b1;
        PIX_VALID     = 1'b0;
        PIX_DATA      = 16'h0;
        bus.EMC_CS_N  = 1'b1;
        bus.EMC_RW_N  = 1'b1;
        bus.EMC_OEN_N = 1'b1;
        bus.EMC_AB    = '0;
        bus.EMC_BYTEN = 2'b11;
        bus.EMC_DB_IN = 16'h0;
        model_reset();
        repeat (3) @(negedge SYSCLK);
        SYSRESET = 1'b0;
        repeat (3) @(negedge SYSCLK);

        // Reset state
        check("rst_cap_en", 32'(CAP_EN), 32'd0);
        check("rst_irq", 32'(IRQ), 32'd0);
        check("rst_oe", 32'(bus.EMC_DB_OE), 32'd0);
        check("rst_db_out", 32'(bus.EMC_DB_OUT), 32'd0);

        // STATUS read with OEN_N held high first: pad must stay released
        @(negedge SYSCLK);
        bus.EMC_AB   = AW'({3'd1, 1'b0});
        bus.EMC_RW_N = 1'b1;
        bus.EMC_CS_N = 1'b0;
        repeat (6) @(negedge SYSCLK);
        check("oe_gated", 32'(bus.EMC_DB_OE), 32'd0);
        bus.EMC_OEN_N = 1'b0;
        #1;
        check("oe_drive", 32'(bus.EMC_DB_OE), 32'd1);
        check("status_reset", 32'(bus.EMC_DB_OUT), 32'h0001);
        @(negedge SYSCLK);
        bus.EMC_CS_N  = 1'b1;
        bus.EMC_OEN_N = 1'b1;
        repeat (5) @(negedge SYSCLK);

        // Basic FIFO ordering
        wr_reg(3'd0, 16'h0001, 2'b00);
        check("cap_en_on", 32'(CAP_EN), 32'd1);
        push_words(3, 1'b0, 16'hA001);
        rd_check("level_3", 3'd3, 8);
        rd_check("data_a001", 3'd2, 8);
        rd_check("data_a002", 3'd2, 8);
        rd_check("data_a003", 3'd2, 8);
        rd_check("level_0", 3'd3, 8);
        rd_check("data_empty", 3'd2, 8);
        rd_check("level_still_0", 3'd3, 8);

        // Overflow and W1C
        push_words(65, 1'b1, 16'h0);
        rd_check("status_full_ovf", 3'd1, 8);
        rd_check("level_64", 3'd3, 8);
        irq_check("irq_masked");
        wr_reg(3'd1, 16'h0004, 2'b00);
        rd_check("status_ovf_clr", 3'd1, 8);
        rd_check("drops", 3'd4, 8);

        // Threshold interrupt
        wr_reg(3'd0, 16'h0003, 2'b00);
        rd_check("level_cleared", 3'd3, 8);
        wr_reg(3'd0, 16'h0005, 2'b00);
        push_words(31, 1'b1, 16'h0);
        irq_check("irq_below");
        @(negedge SYSCLK);
        PIX_VALID = 1'b1;
        PIX_DATA  = 16'h5A5A;
        model_push(16'h5A5A);
        @(negedge SYSCLK);
        PIX_VALID = 1'b0;
        @(negedge SYSCLK);
        check("irq_rise", 32'(IRQ), 32'd1);
        rd_check("data_head", 3'd2, 8);
        rd_check("level_31", 3'd3, 8);
        irq_check("irq_fall");

        // Long access pops once
        lvl = mq.size();
        rd_check("data_long", 3'd2, 20);
        check("level_long", 32'(mq.size()), 32'(lvl - 1));
        rd_check("level_after_long", 3'd3, 8);

        // Byte lanes
        wr_reg(3'd0, 16'h0000, 2'b01);
        rd_check("ctrl_hi_lane_ignored", 3'd0, 8);
        wr_reg(3'd0, 16'h0001, 2'b10);
        rd_check("ctrl_lo_lane", 3'd0, 8);
        rd_check("idx5", 3'd5, 8);

        // Randomized operations
        for (int it = 0; it < 80; it++) begin
            int op;
            op = $urandom_range(0, 7);
            case (op)
                0, 1: push_words($urandom_range(1, 14), 1'b1, 16'h0);
                2, 3: rd_check("rnd_data", 3'd2, $urandom_range(6, 12));
                4:    rd_check("rnd_level", 3'd3, 8);
                5:    rd_check("rnd_status", 3'd1, 8);
                6:    wr_reg(3'd0, {13'd0, 1'($urandom_range(0, 1)),
                                   1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0)},
                             2'($urandom_range(0, 2)));
                default: begin
                    if ($urandom_range(0, 1) == 1) wr_reg(3'd1, 16'h0004, 2'b10);
                    else begin
                        rd_check("rnd_drops", 3'd4, 8);
                        wr_reg(3'd4, 16'h0, 2'b00);
                    end
                end
            endcase
            irq_check("rnd_irq");
        end

        // Reset during RDRIVE
        wr_reg(3'd0, 16'h0001, 2'b00);
        push_words(5, 1'b1, 16'h0);
        rd_check("pre_rst_level", 3'd3, 8);
        @(negedge SYSCLK);
        bus.EMC_AB    = AW'({3'd2, 1'b0});
        bus.EMC_RW_N  = 1'b1;
        bus.EMC_OEN_N = 1'b0;
        bus.EMC_CS_N  = 1'b0;
        seen = 0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge SYSCLK);
            seen = bus.EMC_DB_OE;
        end
        check("rst_rdrive_reached", 32'(seen), 32'd1);
        SYSRESET = 1'b1;
        #1;
        check("rst_oe_drop", 32'(bus.EMC_DB_OE), 32'd0);
        model_reset();
        @(negedge SYSCLK);
        bus.EMC_CS_N  = 1'b1;
        bus.EMC_OEN_N = 1'b1;
        repeat (2) @(negedge SYSCLK);
        SYSRESET = 1'b0;
        repeat (3) @(negedge SYSCLK);
        check("rst_cap_en_again", 32'(CAP_EN), 32'd0);
        rd_check("status_after_rst", 3'd1, 8);
        emc_access(1'b1, 3'd0, 16'h0, 2'b00, 8, got, seen);
        check("ctrl_after_rst", 32'(got), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
